// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arb_pkg
//  Description : Shared definitions for the data-memory arbiter: sequencer
//                state encoding, requester index constants and the default
//                address/data widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_arb_pkg;

    localparam int DEF_AW  = 16;
    localparam int DEF_DW  = 16;

    // Requester indices; also the bit positions in the req/grant vectors.
    localparam int REQ_CPU = 0;
    localparam int REQ_LDR = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_select.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_select
//  Description : Combinational two-way request select. Produces a one-hot
//                winner and an any-request flag. With RR_EN set, a tie goes
//                to the requester that was not granted last; otherwise the
//                CPU requester always wins a tie.
//  Ports       : i_req[1:0]   request vector (bit = requester index)
//                i_lastOwner  index of the most recently granted requester
//                o_grant[1:0] one-hot winner (all zero when no request)
//                o_anyReq     at least one request is pending
//  Config      : RR_EN is driven by the parent from macro DMA_RR_ARB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_select
    import data_mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic [1:0] i_req,
    input  logic       i_lastOwner,
    output logic [1:0] o_grant,
    output logic       o_anyReq
);

    logic w_cpuWins;

    // CPU wins when alone, always under fixed priority, or under round-robin
    // when the loader was the last owner.
    assign w_cpuWins = i_req[REQ_CPU] &
                       (~i_req[REQ_LDR] | ~RR_EN | i_lastOwner);

    assign o_grant[REQ_CPU] = w_cpuWins;
    assign o_grant[REQ_LDR] = i_req[REQ_LDR] & ~w_cpuWins;
    assign o_anyReq         = |i_req;

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Shares the single-port dataMemory between the CPU MEM stage
//                (requester 0) and the loader port (requester 1). Each
//                transaction takes one ACCESS cycle with registered strobes,
//                followed by a DONE cycle with a one-cycle done pulse. A new
//                grant may be decided in the DONE cycle.
//  Ports       : clk, rst (async, active-low)
//                rN_req/we/byte/addr/wdata  requester inputs
//                rN_gnt   high during the owner's ACCESS cycle
//                rN_done  one-cycle completion pulse
//                rN_rdata read data, held until that requester's next read
//                memRead/memWrite/sByte/addr/wrData  memory strobes
//                memOut   combinational memory read data
//  Config      : DMA_RR_ARB_EN defined   -> round-robin arbitration
//                DMA_RR_ARB_EN undefined -> fixed priority, requester 0 wins
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r1_req,
    input  logic          r0_we,
    input  logic          r1_we,
    input  logic          r0_byte,
    input  logic          r1_byte,
    input  logic [AW-1:0] r0_addr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_done,
    output logic          r1_done,
    output logic [DW-1:0] r0_rdata,
    output logic [DW-1:0] r1_rdata,
    output logic          memRead,
    output logic          memWrite,
    output logic          sByte,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wrData,
    input  logic [DW-1:0] memOut
);

`ifdef DMA_RR_ARB_EN
    localparam bit c_RR_EN = 1'b1;
`else
    localparam bit c_RR_EN = 1'b0;
`endif

    arbState_t     r_state,     w_stateNext;
    logic          r_owner,     w_ownerNext;
    logic          r_lastOwner, w_lastOwnerNext;
    logic          r_memRead,   w_memReadNext;
    logic          r_memWrite,  w_memWriteNext;
    logic          r_sByte,     w_sByteNext;
    logic [AW-1:0] r_addr,      w_addrNext;
    logic [DW-1:0] r_wrData,    w_wrDataNext;
    logic [1:0]    r_gnt,       w_gntNext;
    logic [1:0]    r_done,      w_doneNext;
    logic [DW-1:0] r_rdata0,    w_rdata0Next;
    logic [DW-1:0] r_rdata1,    w_rdata1Next;

    logic [1:0]    w_grant;
    logic          w_anyReq;
    logic          w_selWe;
    logic          w_selByte;
    logic [AW-1:0] w_selAddr;
    logic [DW-1:0] w_selWdata;

    mem_arb_select #(
        .RR_EN       (c_RR_EN)
    ) u_select (
        .i_req       ({r1_req, r0_req}),
        .i_lastOwner (r_lastOwner),
        .o_grant     (w_grant),
        .o_anyReq    (w_anyReq)
    );

    // Fields of the arbitration winner (don't-care when nobody requests).
    assign w_selWe    = w_grant[REQ_CPU] ? r0_we    : r1_we;
    assign w_selByte  = w_grant[REQ_CPU] ? r0_byte  : r1_byte;
    assign w_selAddr  = w_grant[REQ_CPU] ? r0_addr  : r1_addr;
    assign w_selWdata = w_grant[REQ_CPU] ? r0_wdata : r1_wdata;

    always_comb begin
        w_stateNext     = r_state;
        w_ownerNext     = r_owner;
        w_lastOwnerNext = r_lastOwner;
        w_memReadNext   = 1'b0;
        w_memWriteNext  = 1'b0;
        w_sByteNext     = r_sByte;
        w_addrNext      = r_addr;
        w_wrDataNext    = r_wrData;
        w_gntNext       = 2'b00;
        w_doneNext      = 2'b00;
        w_rdata0Next    = r_rdata0;
        w_rdata1Next    = r_rdata1;

        case (r_state)
            // IDLE and DONE are both decision cycles.
            IDLE, DONE: begin
                if (w_anyReq) begin
                    w_stateNext     = ACCESS;
                    w_ownerNext     = w_grant[REQ_LDR];
                    w_lastOwnerNext = w_grant[REQ_LDR];
                    w_memReadNext   = ~w_selWe;
                    w_memWriteNext  = w_selWe;
                    w_sByteNext     = w_selByte;
                    w_addrNext      = w_selAddr;
                    w_wrDataNext    = w_selWdata;
                    w_gntNext       = w_grant;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            ACCESS: begin
                w_stateNext         = DONE;
                w_doneNext[r_owner] = 1'b1;
                // memOut is valid now because addr/memRead are registered.
                if (r_memRead) begin
                    if (r_owner) begin
                        w_rdata1Next = memOut;
                    end else begin
                        w_rdata0Next = memOut;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            // Pretend the loader went last so the CPU wins the first tie.
            r_lastOwner <= 1'b1;
            r_memRead   <= 1'b0;
            r_memWrite  <= 1'b0;
            r_sByte     <= 1'b0;
            r_addr      <= '0;
            r_wrData    <= '0;
            r_gnt       <= 2'b00;
            r_done      <= 2'b00;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_owner     <= w_ownerNext;
            r_lastOwner <= w_lastOwnerNext;
            r_memRead   <= w_memReadNext;
            r_memWrite  <= w_memWriteNext;
            r_sByte     <= w_sByteNext;
            r_addr      <= w_addrNext;
            r_wrData    <= w_wrDataNext;
            r_gnt       <= w_gntNext;
            r_done      <= w_doneNext;
            r_rdata0    <= w_rdata0Next;
            r_rdata1    <= w_rdata1Next;
        end
    end

    assign r0_gnt   = r_gnt[REQ_CPU];
    assign r1_gnt   = r_gnt[REQ_LDR];
    assign r0_done  = r_done[REQ_CPU];
    assign r1_done  = r_done[REQ_LDR];
    assign r0_rdata = r_rdata0;
    assign r1_rdata = r_rdata1;
    assign memRead  = r_memRead;
    assign memWrite = r_memWrite;
    assign sByte    = r_sByte;
    assign addr     = r_addr;
    assign wrData   = r_wrData;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Self-checking bench for data_mem_arbiter. A 256-byte memory
//                stand-in sits on the memory port. A timeline model (grant
//                decided in cycle k -> access in k+1, done in k+2, next
//                decision in k+2) with its own memory copy predicts every
//                output each cycle; directed literal checks pin the model.
//  Config      : follows DMA_RR_ARB_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

`ifdef DMA_RR_ARB_EN
    localparam bit       c_RR      = 1'b1;
    localparam bit [3:0] c_EXP_OWN = 4'b1010;
`else
    localparam bit       c_RR      = 1'b0;
    localparam bit [3:0] c_EXP_OWN = 4'b0000;
`endif

    logic        clk, rst;
    logic        r0_req, r1_req, r0_we, r1_we, r0_byte, r1_byte;
    logic [15:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_done, r1_done;
    logic [15:0] r0_rdata, r1_rdata;
    logic        memRead, memWrite, sByte;
    logic [15:0] addr, wrData, memOut;
    logic        memInit, allDone;

    data_mem_arbiter #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_byte(r0_byte), .r1_byte(r1_byte), .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata), .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_done(r0_done), .r1_done(r1_done), .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .memRead(memRead), .memWrite(memWrite), .sByte(sByte), .addr(addr),
        .wrData(wrData), .memOut(memOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] initByte(input int i);
        case (i)
            4:       return 8'h34;
            5:       return 8'h12;
            16:      return 8'hEF;
            17:      return 8'hBE;
            default: return 8'(i * 37 + 5);
        endcase
    endfunction

    // ---------------- memory stand-in (little-endian, byte reads zero-extend)
    logic [7:0] mem [0:255];
    logic [7:0] memA1;
    assign memA1 = addr[7:0] + 8'd1;
    always_comb begin
        memOut = 16'h0000;
        if (memRead) memOut = sByte ? {8'h00, mem[addr[7:0]]} : {mem[memA1], mem[addr[7:0]]};
    end
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= initByte(i);
        end else if (memWrite) begin
            mem[addr[7:0]] <= wrData[7:0];
            if (!sByte) mem[memA1] <= wrData[15:8];
        end
    end

    // ---------------- behavioural timeline model
    logic [7:0]  refMem [0:255];
    int          cyc, accCyc, doneCyc, freeAt;
    bit          mOwner, mWe, mByte, lastOwn;
    logic [15:0] mAddr, mWdata, expRd0, expRd1;

    function automatic bit pickWinner(input bit a, input bit b, input bit last);
        if (a && b) return c_RR ? !last : 1'b0;
        return b;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (memInit) for (int i = 0; i < 256; i++) refMem[i] = initByte(i);
            if (!rst) begin
                cyc = 0; accCyc = -10; doneCyc = -10; freeAt = 0;
                expRd0 = 16'h0; expRd1 = 16'h0; lastOwn = 1'b1;
                mOwner = 1'b0; mWe = 1'b0; mByte = 1'b0; mAddr = 16'h0; mWdata = 16'h0;
            end else begin
                if (cyc == accCyc) begin
                    if (mWe) begin
                        refMem[mAddr[7:0]] = mWdata[7:0];
                        if (!mByte) refMem[8'(mAddr[7:0] + 8'd1)] = mWdata[15:8];
                    end else begin
                        logic [15:0] rv;
                        rv = mByte ? {8'h00, refMem[mAddr[7:0]]}
                                   : {refMem[8'(mAddr[7:0] + 8'd1)], refMem[mAddr[7:0]]};
                        if (mOwner) expRd1 = rv; else expRd0 = rv;
                    end
                end
                if (cyc >= freeAt && (r0_req || r1_req)) begin
                    mOwner  = pickWinner(r0_req, r1_req, lastOwn);
                    mWe     = mOwner ? r1_we    : r0_we;
                    mByte   = mOwner ? r1_byte  : r0_byte;
                    mAddr   = mOwner ? r1_addr  : r0_addr;
                    mWdata  = mOwner ? r1_wdata : r0_wdata;
                    lastOwn = mOwner;
                    accCyc  = cyc + 1;
                    doneCyc = cyc + 2;
                    freeAt  = cyc + 2;
                end
                cyc = cyc + 1;
            end
        end
    end

    // ---------------- directed literal checks are queued here
    string       pinName [0:63];
    logic [31:0] pinAct  [0:63];
    logic [31:0] pinExp  [0:63];
    int          nPins;

    task automatic pin(input string n, input logic [31:0] a, input logic [31:0] e);
        pinName[nPins] = n; pinAct[nPins] = a; pinExp[nPins] = e;
        nPins++;
    endtask

    // ---------------- compare process (sole owner of the counters)
    int checks, errors, pinRd;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", n, a, e, $time);
        end
    endtask

    initial begin
        bit       inAcc, inDone;
        bit [5:0] expCtl;
        checks = 0; errors = 0; pinRd = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && !memInit) begin
                inAcc  = (cyc == accCyc);
                inDone = (cyc == doneCyc);
                expCtl = {inAcc && mOwner, inAcc && !mOwner, inDone && mOwner,
                          inDone && !mOwner, inAcc && !mWe, inAcc && mWe};
                chk("ctl", {26'b0, r1_gnt, r0_gnt, r1_done, r0_done, memRead, memWrite},
                    {26'b0, expCtl});
                if (inAcc) begin
                    chk("addr", {15'b0, sByte, addr}, {15'b0, mByte, mAddr});
                    chk("wrData", {16'b0, wrData}, {16'b0, mWdata});
                end
                chk("rdata0", {16'b0, r0_rdata}, {16'b0, expRd0});
                chk("rdata1", {16'b0, r1_rdata}, {16'b0, expRd1});
            end
            while (pinRd < nPins) begin
                chk(pinName[pinRd], pinAct[pinRd], pinExp[pinRd]);
                pinRd++;
            end
            if (allDone) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus
    task automatic setReq(input int who, input bit rq, input bit we, input bit byt,
                          input logic [15:0] a, input logic [15:0] d);
        if (who == 0) begin
            r0_req = rq; r0_we = we; r0_byte = byt; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = rq; r1_we = we; r1_byte = byt; r1_addr = a; r1_wdata = d;
        end
    endtask

    task automatic randTxn(input int who);
        bit          we, byt;
        logic [15:0] a;
        we  = 1'($urandom_range(0, 1));
        byt = 1'($urandom_range(0, 1));
        a   = byt ? {8'h00, 8'($urandom_range(0, 255))} : {8'h00, 8'($urandom_range(0, 127) * 2)};
        setReq(who, 1'b1, we, byt, a, 16'($urandom));
    endtask

    initial begin
        int          grants, t;
        bit [3:0]    own;
        int          gcyc [0:3];
        bit          got, sawDone;
        nPins = 0; allDone = 1'b0; memInit = 1'b1;
        setReq(0, 0, 0, 0, 16'h0, 16'h0);
        setReq(1, 0, 0, 0, 16'h0, 16'h0);
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        memInit = 1'b0;
        pin("rst_ctl", {26'b0, r1_gnt, r0_gnt, r1_done, r0_done, memRead, memWrite}, 32'h0);
        pin("rst_bus", {15'b0, sByte, addr}, 32'h0);
        pin("rst_rdata", {r1_rdata, r0_rdata}, 32'h0);
        rst = 1'b1;

        // single read of 0x1234 at 0x0004
        @(negedge clk); setReq(0, 1, 0, 0, 16'h0004, 16'h0);
        @(negedge clk);
        pin("t1_gnt", {29'b0, r0_gnt, memRead, r1_gnt}, 32'h6);
        pin("t1_addr", {16'b0, addr}, 32'h4);
        r0_req = 1'b0;
        @(negedge clk);
        pin("t1_done", {30'b0, r0_done, r1_done}, 32'h2);
        pin("t1_rdata", {r1_rdata, r0_rdata}, 32'h0000_1234);

        // word write then byte write from the loader, read back via the CPU
        @(negedge clk); setReq(1, 1, 1, 0, 16'h0000, 16'h0FFF);
        @(negedge clk);
        pin("t2_wword", {28'b0, r1_gnt, memWrite, memRead, sByte}, 32'hC);
        setReq(1, 1, 1, 1, 16'h0002, 16'h55AA);
        @(negedge clk);
        @(negedge clk);
        pin("t2_wbyte", {28'b0, r1_gnt, memWrite, memRead, sByte}, 32'hD);
        r1_req = 1'b0;
        @(negedge clk); setReq(0, 1, 0, 0, 16'h0000, 16'h0);
        @(negedge clk); r0_req = 1'b0;
        @(negedge clk); pin("t2_rd_word", {16'b0, r0_rdata}, 32'h0FFF);
        setReq(0, 1, 0, 0, 16'h0002, 16'h0);
        @(negedge clk); r0_req = 1'b0;
        @(negedge clk); pin("t2_rd_byte", {24'b0, r0_rdata[7:0]}, 32'hAA);

        // simultaneous requests from reset
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        setReq(0, 1, 0, 0, 16'h0004, 16'h0);
        setReq(1, 1, 0, 0, 16'h0010, 16'h0);
        grants = 0; t = 0; own = 4'b0;
        while (grants < 4 && t < 40) begin
            @(negedge clk);
            t++;
            if (r0_gnt || r1_gnt) begin
                own[grants]  = r1_gnt;
                gcyc[grants] = t;
                grants++;
            end
        end
        pin("t3_grants", grants, 4);
        if (grants == 4) begin
            pin("t3_owners", {28'b0, own}, {28'b0, c_EXP_OWN});
            pin("t3_spacing", gcyc[3] - gcyc[0], 6);
        end
        r0_req = 1'b0;
        if (own[3]) r1_req = 1'b0;
        if (r1_req) begin
            got = 1'b0;
            for (int k = 0; k < 6 && !got; k++) begin
                @(negedge clk);
                got = r1_gnt;
            end
            pin("t3_r1_served", {31'b0, got}, 32'h1);
            r1_req = 1'b0;
        end
        repeat (3) @(negedge clk);

        // rdata hold across the other requester's read
        setReq(0, 1, 0, 0, 16'h0004, 16'h0);
        @(negedge clk); r0_req = 1'b0;
        @(negedge clk); pin("t5_r0", {16'b0, r0_rdata}, 32'h1234);
        setReq(1, 1, 0, 0, 16'h0010, 16'h0);
        @(negedge clk); pin("t5_r0_acc", {16'b0, r0_rdata}, 32'h1234); r1_req = 1'b0;
        @(negedge clk);
        pin("t5_pair", {r1_rdata, r0_rdata}, 32'hBEEF_1234);

        // reset during ACCESS of a CPU read
        @(negedge clk); setReq(0, 1, 0, 0, 16'h0004, 16'h0);
        @(negedge clk);
        pin("t4_acc", {30'b0, r0_gnt, memRead}, 32'h3);
        #1 rst = 1'b0;
        #1;
        pin("t4_clr", {r0_rdata, 14'b0, r0_gnt, memRead}, 32'h0);
        r0_req = 1'b0;
        @(negedge clk); rst = 1'b1;
        sawDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sawDone = sawDone | r0_done;
        end
        pin("t4_no_done", {31'b0, sawDone}, 32'h0);

        // randomized traffic from both requesters
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (r0_req && r0_gnt) begin
                if ($urandom_range(0, 2) == 0) randTxn(0); else r0_req = 1'b0;
            end else if (!r0_req && $urandom_range(0, 1) == 1) randTxn(0);
            if (r1_req && r1_gnt) begin
                if ($urandom_range(0, 2) == 0) randTxn(1); else r1_req = 1'b0;
            end else if (!r1_req && $urandom_range(0, 1) == 1) randTxn(1);
        end
        @(negedge clk);
        while (r0_req || r1_req) begin
            if (r0_gnt) r0_req = 1'b0;
            if (r1_gnt) r1_req = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        allDone = 1'b1;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the processor's 16-bit `dataMemory`. It shares that single memory between two requesters:
- requester 0: the CPU MEM stage;
- requester 1: the program/debug loader port.

For each transaction it accepts the request, drives the memory strobes (`memRead`/`memWrite`/`sByte`/`addr`/`wrData`) for exactly one cycle, captures read data from `memOut`, and returns it with a one-cycle `done` pulse.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- r0_req, r1_req  input  1  request, level, held until gnt
- r0_we, r1_we  input  1  1 = write, 0 = read
- r0_byte, r1_byte  input  1  byte access (maps to sByte)
- r0_addr, r1_addr  input  AW  byte address
- r0_wdata, r1_wdata  input  DW  write data (low byte used when byte=1)
- r0_gnt, r1_gnt  output  1  request accepted; high during ACCESS cycle
- r0_done, r1_done  output  1  one-cycle completion pulse
- r0_rdata, r1_rdata  output  DW  read data, valid from done, held until that requester's next read completes
- memRead, memWrite  output  1  memory strobes
- sByte  output  1  byte-access select to memory
- addr  output  AW  memory address
- wrData  output  DW  memory write data
- memOut  input  DW  memory read data, combinational from addr/memRead

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: arbitrate.
  - If any req: latch the winner's we/byte/addr/wdata into the memory output registers and record the owner; next state ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Owner's gnt = 1.
  - memRead = ~we, memWrite = we; sByte/addr/wrData are the latched values.
  - On a read, memOut is registered into the owner's rdata at the end of the cycle.
  - Next state DONE.
- DONE:
  - Owner's done = 1; strobes are 0.
  - Arbitrate again: if any req, latch it and go directly to ACCESS; else go to IDLE.
- Requester rules:
  - Hold req and its fields stable until gnt is seen.
  - Drop req at the edge ending the gnt cycle, unless it is issuing a new transaction.
  - A req still high in a DONE or IDLE cycle is a new transaction.
- Strobes are registered and never glitch. memRead and memWrite are never both 1.
- rdata is never modified by writes or by the other requester's reads.
- Reset values: state IDLE; all gnt/done 0; memRead/memWrite/sByte 0; addr/wrData 0; both rdata 0; round-robin pointer = requester 0 favoured.
- Reset asserted mid-transaction:
  - Everything returns immediately (asynchronously) to its reset value.
  - An in-flight write may or may not have reached memory.
  - No done is issued for the aborted transaction.

## Timing
- Request seen in IDLE cycle N: gnt and strobes in cycle N+1, done and rdata valid in cycle N+2.
- Back-to-back: a new grant can be decided in the DONE cycle, giving one memory access every 2 cycles.
- Write is committed by the memory at the rising edge ending the ACCESS cycle.
- Both req high in the same decision cycle: resolved per Configuration. The loser keeps req high and is served in the next decision cycle unless it loses again.

## Configuration
- DMA_RR_ARB_EN defined:
  - Round-robin between the two requesters.
  - A one-bit pointer records the last owner and flips on every grant.
  - On a tie, the requester that was not last granted wins.
  - Neither requester waits more than one transaction.
- DMA_RR_ARB_EN undefined:
  - Fixed priority, requester 0 always wins.
  - Requester 1 can starve while r0_req stays high; this is accepted behaviour.

## Structure
- Shared package/include data_mem_arb_pkg:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2);
  - requester index constants (REQ_CPU = 0, REQ_LDR = 1);
  - default AW/DW.
- One sub-module, mem_arb_select: combinational 2-way select (fixed or round-robin) from req[1:0] and the pointer, producing a one-hot winner and any_req. The pointer register lives in the parent.

## Test plan
- Reset then single read: preload mem[0x0004] = 0x1234; r0 read at addr 0x0004 → r0_gnt and memRead in cycle N+1, r0_done with r0_rdata = 0x1234 in N+2; r1 outputs stay 0.
- Word then byte write: r1 word write 0x0FFF @0x0000, then r1 byte write 0xAA @0x0002 → memWrite one cycle each, sByte = 0 then 1. Readback via r0 gives 0x0FFF and a low byte of 0xAA.
- Simultaneous requests, DMA_RR_ARB_EN defined: both req every decision cycle for 4 transactions → owners alternate 0,1,0,1, with a grant every 2 cycles.
- Same stimulus with the macro undefined → requester 0 wins all 4; r1_gnt stays 0 until r0_req drops, then r1 is granted.
- Reset mid-ACCESS: assert rst low during r0 read ACCESS → memRead, r0_gnt, state and r0_rdata return to 0 immediately; no r0_done after release.
- rdata hold: r0 read returns 0x1234, then r1 read returns 0xBEEF → r0_rdata remains 0x1234 throughout.
